// File: rtl/imem_port_arbiter.sv
// Instruction memory port arbiter: fetch (RO) vs loader (RW), 1-cycle response.
// Optional grant statistics and trace enabled by defining IMEM_ARB_STATS_EN.
module imem_port_arbiter #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          AW          = 8,
  parameter int          STARVE_LIM  = 4,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_err,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [31:0]   ld_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
`ifdef IMEM_ARB_STATS_EN
  input  logic [31:0]   mem_rdata,
  input  logic          stat_clr,
  output logic [31:0]   stat_fetch_cnt,
  output logic [31:0]   stat_ld_cnt,
  output logic [31:0]   stat_conflict_cnt
`else
  input  logic [31:0]   mem_rdata
`endif
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_FETCH,
    RSP_LOAD
  } rsp_e;

  rsp_e          r_state;
  rsp_e          w_state_nxt;
  logic [SW-1:0] r_starve;
  logic          r_f_err;
  logic          r_ld_zero;

  logic          w_f_mis;
  logic          w_f_oor;
  logic          w_f_err;
  logic          w_ld_oor;
  logic          w_starved;
  logic          w_ld_win;
  logic          w_f_win;
  logic          w_unused;

  assign w_unused = ^ld_addr[1:0];

  assign w_f_mis  = |fetch_addr[1:0];
  assign w_f_oor  = {2'b00, fetch_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign w_f_err  = w_f_mis | w_f_oor;
  assign w_ld_oor = {2'b00, ld_addr[31:2]} >= 32'(DEPTH_WORDS);

  // Loader normally yields to fetch; wins once it has waited long enough.
  assign w_starved = r_starve >= SW'(STARVE_LIM);
  assign w_ld_win  = ld_req & (~fetch_req | w_starved);
  assign w_f_win   = fetch_req & ~w_ld_win;

  assign fetch_gnt = rst_n & w_f_win;
  assign ld_gnt    = rst_n & w_ld_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      ld_gnt: begin
        mem_en    = ~w_ld_oor;
        mem_we    = ~w_ld_oor & ld_we;
        mem_addr  = ld_addr[AW+1:2];
        mem_wdata = ld_wdata;
      end
      fetch_gnt: begin
        mem_en   = ~w_f_err;
        mem_addr = fetch_addr[AW+1:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (ld_gnt) begin
      r_starve <= '0;
    end else if (ld_req && !w_starved) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RSP_NONE;
      r_f_err   <= 1'b0;
      r_ld_zero <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_f_err   <= fetch_gnt & w_f_err;
      r_ld_zero <= ld_gnt & (ld_we | w_ld_oor);
    end
  end

  always_comb begin
    w_state_nxt  = RSP_NONE;
    fetch_rvalid = 1'b0;
    fetch_err    = 1'b0;
    fetch_rdata  = '0;
    ld_rvalid    = 1'b0;
    ld_rdata     = '0;
    if (ld_gnt) begin
      w_state_nxt = RSP_LOAD;
    end else if (fetch_gnt) begin
      w_state_nxt = RSP_FETCH;
    end
    unique case (r_state)
      RSP_FETCH: begin
        fetch_rvalid = 1'b1;
        fetch_err    = r_f_err;
        fetch_rdata  = r_f_err ? NOP_WORD : mem_rdata;
      end
      RSP_LOAD: begin
        ld_rvalid = 1'b1;
        ld_rdata  = r_ld_zero ? 32'h0 : mem_rdata;
      end
      default: ;
    endcase
  end

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] r_stat_f;
  logic [31:0] r_stat_l;
  logic [31:0] r_stat_c;

  assign stat_fetch_cnt    = r_stat_f;
  assign stat_ld_cnt       = r_stat_l;
  assign stat_conflict_cnt = r_stat_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_f <= '0;
      r_stat_l <= '0;
      r_stat_c <= '0;
    end else if (stat_clr) begin
      r_stat_f <= '0;
      r_stat_l <= '0;
      r_stat_c <= '0;
    end else begin
      r_stat_f <= r_stat_f + {31'h0, fetch_gnt};
      r_stat_l <= r_stat_l + {31'h0, ld_gnt};
      r_stat_c <= r_stat_c + {31'h0, fetch_req & ld_req};
    end
  end

  always @(posedge clk) begin
    if (fetch_gnt)
      $display("[IMEM] %0t FETCH addr=%08h", $time, fetch_addr);
    if (ld_gnt)
      $display("[IMEM] %0t LOAD  addr=%08h", $time, ld_addr);
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter with a sync-read memory model.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        fetch_err;
  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];

  int n_run;
  int n_fail;

  imem_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .fetch_err    (fetch_err),
    .ld_req       (ld_req),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_wdata     (ld_wdata),
    .ld_gnt       (ld_gnt),
    .ld_rvalid    (ld_rvalid),
    .ld_rdata     (ld_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic test_reset;
    rst_n      = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h10;
    ld_req     = 1'b1;
    ld_we      = 1'b1;
    ld_addr    = 32'h20;
    ld_wdata   = 32'h55;
    #2;
    n_run++; if (fetch_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_frvalid got=%0h exp=0", fetch_rvalid); end
    n_run++; if (ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_lrvalid got=%0h exp=0", ld_rvalid); end
    n_run++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL rst_ferr got=%0h exp=0", fetch_err); end
    n_run++; if (fetch_rdata !== 32'h0 || ld_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h/%h exp=0/0", fetch_rdata, ld_rdata); end
    n_run++; if (fetch_gnt !== 1'b0 || ld_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt got=%0h/%0h exp=0/0", fetch_gnt, ld_gnt); end
    n_run++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem got=%0h/%0h/%h/%h exp=0", mem_en, mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    rst_n     = 1'b1;
    fetch_req = 1'b0;
    ld_req    = 1'b0;
    ld_we     = 1'b0;
  endtask

  task automatic test_write_then_fetch;
    @(negedge clk);
    ld_req   = 1'b1;
    ld_we    = 1'b1;
    ld_addr  = 32'h0;
    ld_wdata = 32'h08002083;
    #1;
    n_run++; if (ld_gnt !== 1'b1 || fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL wr_gnt got=%0h/%0h exp=1/0", ld_gnt, fetch_gnt); end
    n_run++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h0) begin n_fail++; $display("FAIL wr_mem got=%0h/%0h/%h exp=1/1/00", mem_en, mem_we, mem_addr); end
    @(posedge clk); #1;
    n_run++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_ack got=%0h/%h exp=1/00000000", ld_rvalid, ld_rdata); end
    @(negedge clk);
    ld_req     = 1'b0;
    ld_we      = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    #1;
    n_run++; if (fetch_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_gnt got=%0h/%0h/%0h exp=1/1/0", fetch_gnt, mem_en, mem_we); end
    @(posedge clk); #1;
    n_run++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h08002083 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL rd_rsp got=%0h/%h/%0h exp=1/08002083/0", fetch_rvalid, fetch_rdata, fetch_err); end
    n_run++; if (ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_lrvalid got=%0h exp=0", ld_rvalid); end
    @(negedge clk);
    fetch_req = 1'b0;
    @(posedge clk); #1;
    n_run++; if (fetch_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse got=%0h exp=0", fetch_rvalid); end
  endtask

  task automatic test_starvation;
    logic exp_l [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        ld_req     = 1'b1;
        ld_we      = 1'b0;
        ld_addr    = 32'h4;
      end
      #1;
      n_run++; if (ld_gnt !== exp_l[i] || fetch_gnt !== !exp_l[i]) begin n_fail++; $display("FAIL starve_gnt%0d got=%0h/%0h exp=%0h/%0h", i, fetch_gnt, ld_gnt, !exp_l[i], exp_l[i]); end
      @(posedge clk); #1;
      if (exp_l[i]) begin
        n_run++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'hA0000001) begin n_fail++; $display("FAIL starve_lrsp got=%0h/%h exp=1/a0000001", ld_rvalid, ld_rdata); end
      end else begin
        n_run++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h08002083) begin n_fail++; $display("FAIL starve_frsp%0d got=%0h/%h exp=1/08002083", i, fetch_rvalid, fetch_rdata); end
      end
    end
    @(negedge clk);
    fetch_req = 1'b0;
    ld_req    = 1'b0;
  endtask

  task automatic test_fetch_err;
    logic [31:0] addrs [2] = '{32'h6, 32'h400};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      fetch_req  = 1'b1;
      fetch_addr = addrs[i];
      #1;
      n_run++; if (fetch_gnt !== 1'b1 || mem_en !== 1'b0) begin n_fail++; $display("FAIL ferr_gnt%0d got=%0h/%0h exp=1/0", i, fetch_gnt, mem_en); end
      @(posedge clk); #1;
      n_run++; if (fetch_rvalid !== 1'b1 || fetch_err !== 1'b1 || fetch_rdata !== 32'h13) begin n_fail++; $display("FAIL ferr_rsp%0d got=%0h/%0h/%h exp=1/1/00000013", i, fetch_rvalid, fetch_err, fetch_rdata); end
    end
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  task automatic test_ld_oor;
    logic we_v [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ld_req   = 1'b1;
      ld_we    = we_v[i];
      ld_addr  = 32'h400;
      ld_wdata = 32'hDEADBEEF;
      #1;
      n_run++; if (ld_gnt !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL loor_gnt%0d got=%0h/%0h/%0h exp=1/0/0", i, ld_gnt, mem_en, mem_we); end
      @(posedge clk); #1;
      n_run++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'h0) begin n_fail++; $display("FAIL loor_ack%0d got=%0h/%h exp=1/00000000", i, ld_rvalid, ld_rdata); end
    end
    @(negedge clk);
    ld_req     = 1'b0;
    ld_we      = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    @(posedge clk); #1;
    n_run++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h08002083) begin n_fail++; $display("FAIL loor_word0 got=%0h/%h exp=1/08002083", fetch_rvalid, fetch_rdata); end
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [3] = '{32'h08002083, 32'hA0000001, 32'hA0000002};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fetch_req  = 1'b1;
      fetch_addr = 32'(4 * i);
      #1;
      n_run++; if (fetch_gnt !== 1'b1 || mem_addr !== 8'(i)) begin n_fail++; $display("FAIL b2b_gnt%0d got=%0h/%h exp=1/%h", i, fetch_gnt, mem_addr, 8'(i)); end
      @(posedge clk); #1;
      n_run++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== exp_d[i]) begin n_fail++; $display("FAIL b2b_rsp%0d got=%0h/%h exp=1/%h", i, fetch_rvalid, fetch_rdata, exp_d[i]); end
    end
    @(negedge clk);
    fetch_req = 1'b0;
    @(posedge clk); #1;
    n_run++; if (fetch_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got=%0h exp=0", fetch_rvalid); end
  endtask

  task automatic test_reset_mid;
    logic exp_l [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    ld_req     = 1'b1;
    ld_we      = 1'b0;
    ld_addr    = 32'h4;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_run++; if (fetch_rvalid !== 1'b0 || fetch_rdata !== 32'h0 || ld_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp got=%0h/%h/%0h exp=0/0/0", fetch_rvalid, fetch_rdata, ld_rvalid); end
    n_run++; if (fetch_gnt !== 1'b0 || ld_gnt !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL mid_gnt got=%0h/%0h/%0h exp=0/0/0", fetch_gnt, ld_gnt, mem_en); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_run++; if (ld_gnt !== exp_l[i] || fetch_gnt !== !exp_l[i]) begin n_fail++; $display("FAIL mid_gnt%0d got=%0h/%0h exp=%0h/%0h", i, fetch_gnt, ld_gnt, !exp_l[i], exp_l[i]); end
      @(posedge clk); #1;
      if (i == 0) begin
        n_run++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h08002083) begin n_fail++; $display("FAIL mid_first got=%0h/%h exp=1/08002083", fetch_rvalid, fetch_rdata); end
      end
      @(negedge clk);
    end
    fetch_req = 1'b0;
    ld_req    = 1'b0;
  endtask

  initial begin
    n_run      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    ld_req     = 1'b0;
    ld_we      = 1'b0;
    ld_addr    = '0;
    ld_wdata   = '0;
    mem_rdata  = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA0000000 | 32'(i);
    test_reset();
    test_write_then_fetch();
    test_starvation();
    test_fetch_err();
    test_ld_oor();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
